// File: rtl/fifo_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_reader_pkg
//  Description : Shared defaults and helpers for the FIFO consumer slice.
//                DATA_SIZE / CNT_W defaults are common to the FIFO, the
//                reader and the stimulus generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_reader_pkg;

    localparam int c_DATA_SIZE  = 6;   // FIFO word width
    localparam int c_CNT_W      = 8;   // delivered-word counter width
    localparam int c_SKID_DEPTH = 3;   // skid queue entries (only 3 supported)

    // Last valid index of the 3-entry circular buffer.
    localparam logic [1:0] c_PTR_LAST = 2'd2;

    // Circular pointer increment wrapping 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == c_PTR_LAST) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_reader_skid.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_reader_skid
//  Description : 3-entry circular skid queue absorbing the FIFO read latency.
//                head_data is taken straight from registered storage (no
//                bypass from push_data).
//  Ports       : clk, reset_L    - clock, async active-low reset
//                push, push_data - enqueue a word at the tail
//                pop             - dequeue the head word
//                head_data       - oldest stored word
//                occupancy       - number of stored words (0..3)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int DATA_SIZE = c_DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_SIZE-1:0] head_data,
    output logic [1:0]           occupancy
);

    logic [DATA_SIZE-1:0] r_mem [0:c_SKID_DEPTH-1];
    logic [1:0]           r_head;
    logic [1:0]           r_tail;
    logic [1:0]           r_occ;
    logic                 w_pop;
    logic                 w_push;

    // Pop of an empty queue is ignored; a push into a full queue is only
    // accepted if a pop frees the head slot in the same cycle.
    assign w_pop  = pop & (r_occ != 2'd0);
    assign w_push = push & ((r_occ != 2'd3) | w_pop);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < c_SKID_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_head <= 2'd0;
            r_tail <= 2'd0;
            r_occ  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= push_data;
                r_tail        <= ptr_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= ptr_inc(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign head_data = r_mem[r_head];
    assign occupancy = r_occ;

endmodule
`default_nettype wire

// File: rtl/fifo_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_reader
//  Description : Consumer-side FIFO controller. Pops the FIFO through its
//                read/fifo_empty interface, re-presents words downstream on a
//                valid/ready handshake, counts delivered words and latches
//                fifo_error.
//  Ports       : clk, reset_L        - clock, async active-low reset
//                enable              - allow new FIFO reads
//                fifo_empty          - FIFO empty flag
//                buffer_out          - FIFO data, valid the cycle after read
//                fifo_error          - FIFO overflow/underflow flag
//                read                - FIFO pop request
//                data_out, valid_out - downstream word and its valid
//                ready_in            - downstream accept
//                word_count          - words delivered downstream (wraps)
//                clear_err           - clear err_sticky
//                err_sticky          - latched fifo_error
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_SIZE  = c_DATA_SIZE,
    parameter int CNT_W      = c_CNT_W,
    parameter int SKID_DEPTH = c_SKID_DEPTH
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] buffer_out,
    input  logic                 fifo_error,
    output logic                 read,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic [CNT_W-1:0]     word_count,
    input  logic                 clear_err,
    output logic                 err_sticky
);

    localparam logic [2:0] c_DEPTH = 3'(SKID_DEPTH);

    logic             r_inflight;
    logic [CNT_W-1:0] r_word_count;
    logic             r_err_sticky;
    logic [1:0]       w_occ;
    logic [2:0]       w_fill;
    logic             w_read;
    logic             w_pop;

    // Words already committed to the queue: stored ones plus the one whose
    // data arrives on buffer_out this cycle. Reads stop once that would
    // exceed the queue depth, so ready_in never reaches read.
    assign w_fill = {1'b0, w_occ} + {2'b00, r_inflight};
    assign w_read = reset_L & enable & ~fifo_empty & (w_fill < c_DEPTH);
    assign w_pop  = valid_out & ready_in;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_inflight   <= 1'b0;
            r_word_count <= '0;
            r_err_sticky <= 1'b0;
        end else begin
            r_inflight <= w_read;
            if (w_pop) begin
                r_word_count <= r_word_count + CNT_W'(1);
            end
            // Set has priority over clear.
            if (fifo_error) begin
                r_err_sticky <= 1'b1;
            end else if (clear_err) begin
                r_err_sticky <= 1'b0;
            end
        end
    end

    fifo_reader_skid #(
        .DATA_SIZE (DATA_SIZE)
    ) u_skid (
        .clk       (clk),
        .reset_L   (reset_L),
        .push      (r_inflight),
        .push_data (buffer_out),
        .pop       (w_pop),
        .head_data (data_out),
        .occupancy (w_occ)
    );

    assign read       = w_read;
    assign valid_out  = (w_occ != 2'd0);
    assign word_count = r_word_count;
    assign err_sticky = r_err_sticky;

endmodule
`default_nettype wire
